// File: rtl/fighter_pkg.sv
// Shared state codes, stun codes and default frame timings for the fighter controller.
package fighter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FORWARD   = 4'd1,
    ST_BACKWARD  = 4'd2,
    ST_I_START   = 4'd3,
    ST_I_ACTIVE  = 4'd4,
    ST_I_RECOV   = 4'd5,
    ST_D_START   = 4'd6,
    ST_D_ACTIVE  = 4'd7,
    ST_D_RECOV   = 4'd8,
    ST_HITSTUN   = 4'd9,
    ST_BLOCKSTUN = 4'd10,
    ST_KO        = 4'd11
  } state_e;

  localparam logic [1:0] STUN_HIT   = 2'b01;
  localparam logic [1:0] STUN_BLOCK = 2'b10;

  localparam int CNT_W          = 5;
  localparam int DEF_I_STARTUP  = 5;
  localparam int DEF_I_ACTIVE   = 2;
  localparam int DEF_I_RECOVERY = 16;
  localparam int DEF_D_STARTUP  = 4;
  localparam int DEF_D_ACTIVE   = 3;
  localparam int DEF_D_RECOVERY = 15;
  localparam int DEF_HITSTUN    = 14;
  localparam int DEF_BLOCKSTUN  = 12;

endpackage

// File: rtl/fighter_controller_frame_timer.sv
// Per-phase frame counter: clears on request, otherwise counts up and saturates.
module frame_timer
  import fighter_pkg::*;
(
  input  logic             logic_clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge logic_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A phase of N frames ends on its last frame, counter N-1.
  assign done_o = (cnt_q == (dur_i - {{(CNT_W-1){1'b0}}, 1'b1}));
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/fighter_controller.sv
// One-player fighter state machine: movement, two attack kinds with recovery buffering,
// hit/block stun, health and KO.
module fighter_controller
  import fighter_pkg::*;
#(
  parameter int POS_W        = 10,
  parameter int PLAYER_WIDTH = 64,
  parameter int SPEED_FWD    = 3,
  parameter int SPEED_BWD    = 2,
  parameter int FACING       = 0,
  parameter int START_X      = 10,
  parameter int I_STARTUP    = DEF_I_STARTUP,
  parameter int I_ACTIVE     = DEF_I_ACTIVE,
  parameter int I_RECOVERY   = DEF_I_RECOVERY,
  parameter int D_STARTUP    = DEF_D_STARTUP,
  parameter int D_ACTIVE     = DEF_D_ACTIVE,
  parameter int D_RECOVERY   = DEF_D_RECOVERY,
  parameter int HITSTUN      = DEF_HITSTUN,
  parameter int BLOCKSTUN    = DEF_BLOCKSTUN,
  parameter int HP_W         = 7,
  parameter int HP_MAX       = 100,
  parameter int DMG_I        = 10,
  parameter int DMG_D        = 15,
  parameter int BUF_WIN      = 4
)(
  input  logic             logic_clk,
  input  logic             reset,
  input  logic             in_left,
  input  logic             in_right,
  input  logic             attack,
  input  logic [POS_W-1:0] opp_pos_x,
  input  logic [POS_W-1:0] left_bound,
  input  logic [POS_W-1:0] right_bound,
  input  logic [1:0]       stunmode,
  input  logic             opp_dir_attack,
  input  logic             own_hit,
  output logic [POS_W-1:0] pos_x,
  output logic [3:0]       state,
  output logic             move_flag,
  output logic             attack_flag,
  output logic             is_directional_attack,
  output logic [HP_W-1:0]  health,
  output logic             ko
);

  localparam logic [POS_W:0] PW_X = (POS_W+1)'(PLAYER_WIDTH);
  localparam logic [POS_W:0] SF_X = (POS_W+1)'(SPEED_FWD);
  localparam logic [POS_W:0] SB_X = (POS_W+1)'(SPEED_BWD);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, fwd_pos_s, bwd_pos_s;
  logic [HP_W-1:0]  health_q, health_d, dmg_s;
  logic             buf_vld_q, buf_vld_d, buf_dir_q, buf_dir_d, buf_vld_s, buf_dir_s;
  logic [CNT_W-1:0] cnt_s, dur_s;
  logic             done_s, clr_s, restart_s, hit_apply_s;
  logic             dir_held_s, fwd_held_s, bwd_held_s, fwd_ok_s, bwd_ok_s, in_buf_win_s;
  logic [POS_W:0]   pos_x_s, opp_x_s, lb_x_s, rb_x_s;
  logic [6:0]       rec_dur_s;

  frame_timer u_timer (
    .logic_clk (logic_clk),
    .reset     (reset),
    .clr_i     (clr_s),
    .dur_i     (dur_s),
    .cnt_o     (cnt_s),
    .done_o    (done_s)
  );

  // Pressing both directions counts as no direction at all.
  assign dir_held_s = in_left ^ in_right;
  assign fwd_held_s = (FACING == 0) ? (in_right & ~in_left) : (in_left & ~in_right);
  assign bwd_held_s = (FACING == 0) ? (in_left & ~in_right) : (in_right & ~in_left);

  assign pos_x_s = {1'b0, pos_q};
  assign opp_x_s = {1'b0, opp_pos_x};
  assign lb_x_s  = {1'b0, left_bound};
  assign rb_x_s  = {1'b0, right_bound};

  assign fwd_ok_s = (FACING == 0)
      ? ((pos_x_s + PW_X + SF_X <= opp_x_s) && (pos_x_s + PW_X + SF_X <= rb_x_s))
      : ((pos_x_s >= opp_x_s + PW_X + SF_X) && (pos_x_s >= lb_x_s + SF_X));
  assign bwd_ok_s = (FACING == 0)
      ? (pos_x_s >= lb_x_s + SB_X)
      : (pos_x_s + PW_X + SB_X <= rb_x_s);
  assign fwd_pos_s = (FACING == 0) ? (pos_q + POS_W'(SPEED_FWD)) : (pos_q - POS_W'(SPEED_FWD));
  assign bwd_pos_s = (FACING == 0) ? (pos_q - POS_W'(SPEED_BWD)) : (pos_q + POS_W'(SPEED_BWD));

  assign rec_dur_s    = (state_q == ST_D_RECOV) ? 7'(D_RECOVERY) : 7'(I_RECOVERY);
  assign in_buf_win_s = (({2'b00, cnt_s} + 7'(BUF_WIN)) >= rec_dur_s);
  assign dmg_s        = opp_dir_attack ? HP_W'(DMG_D) : HP_W'(DMG_I);

  always_comb begin
    case (state_q)
      ST_I_START:   dur_s = CNT_W'(I_STARTUP);
      ST_I_ACTIVE:  dur_s = CNT_W'(I_ACTIVE);
      ST_I_RECOV:   dur_s = CNT_W'(I_RECOVERY);
      ST_D_START:   dur_s = CNT_W'(D_STARTUP);
      ST_D_ACTIVE:  dur_s = CNT_W'(D_ACTIVE);
      ST_D_RECOV:   dur_s = CNT_W'(D_RECOVERY);
      ST_HITSTUN:   dur_s = CNT_W'(HITSTUN);
      ST_BLOCKSTUN: dur_s = CNT_W'(BLOCKSTUN);
      default:      dur_s = {CNT_W{1'b1}};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    restart_s = 1'b0;
    buf_vld_s = buf_vld_q;
    buf_dir_s = buf_dir_q;
    if (health_q == {HP_W{1'b0}}) begin
      state_d = ST_KO;
    end else begin
      case (state_q)
        ST_IDLE, ST_FORWARD, ST_BACKWARD: begin
          if (stunmode == STUN_HIT) begin
            state_d = ST_HITSTUN;
          end else if (stunmode == STUN_BLOCK) begin
            state_d = ST_BLOCKSTUN;
          end else if (attack && dir_held_s) begin
            state_d = ST_D_START;
          end else if (attack) begin
            state_d = ST_I_START;
          end else if (fwd_held_s && fwd_ok_s) begin
            state_d = ST_FORWARD;
            pos_d   = fwd_pos_s;
          end else if (bwd_held_s && bwd_ok_s) begin
            state_d = ST_BACKWARD;
            pos_d   = bwd_pos_s;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_I_START:  state_d = done_s ? ST_I_ACTIVE : ST_I_START;
        ST_I_ACTIVE: state_d = (own_hit || done_s) ? ST_I_RECOV : ST_I_ACTIVE;
        ST_D_START:  state_d = done_s ? ST_D_ACTIVE : ST_D_START;
        ST_D_ACTIVE: state_d = done_s ? ST_D_RECOV : ST_D_ACTIVE;
        ST_I_RECOV, ST_D_RECOV: begin
          // The press seen on the exit frame still counts toward the buffer.
          if (attack && in_buf_win_s) begin
            buf_vld_s = 1'b1;
            buf_dir_s = dir_held_s;
          end else begin
            buf_vld_s = buf_vld_q;
            buf_dir_s = buf_dir_q;
          end
          if (stunmode == STUN_HIT) begin
            state_d = ST_HITSTUN;
          end else if (done_s) begin
            state_d = !buf_vld_s ? ST_IDLE : (buf_dir_s ? ST_D_START : ST_I_START);
          end else begin
            state_d = state_q;
          end
        end
        ST_HITSTUN: begin
          if (stunmode == STUN_HIT) begin
            restart_s = 1'b1;
            state_d   = ST_HITSTUN;
          end else if (done_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HITSTUN;
          end
        end
        ST_BLOCKSTUN: state_d = done_s ? ST_IDLE : ST_BLOCKSTUN;
        ST_KO:        state_d = ST_KO;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  assign clr_s       = (state_d != state_q) || restart_s;
  assign hit_apply_s = (state_d == ST_HITSTUN) && ((state_q != ST_HITSTUN) || restart_s);
  assign health_d    = !hit_apply_s ? health_q
                     : ((health_q > dmg_s) ? (health_q - dmg_s) : {HP_W{1'b0}});
  assign buf_vld_d   = (state_d == state_q) ? buf_vld_s : 1'b0;
  assign buf_dir_d   = (state_d == state_q) ? buf_dir_s : 1'b0;

  always_ff @(posedge logic_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pos_q     <= POS_W'(START_X);
      health_q  <= HP_W'(HP_MAX);
      buf_vld_q <= 1'b0;
      buf_dir_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      health_q  <= health_d;
      buf_vld_q <= buf_vld_d;
      buf_dir_q <= buf_dir_d;
    end
  end

  always_comb begin
    move_flag             = (state_q == ST_FORWARD) || (state_q == ST_BACKWARD);
    attack_flag           = (state_q == ST_I_ACTIVE);
    is_directional_attack = (state_q == ST_D_ACTIVE);
    ko                    = (state_q == ST_KO);
  end

  assign pos_x  = pos_q;
  assign state  = state_q;
  assign health = health_q;

endmodule

// File: tb/tb_fighter_controller.sv
// Directed scoreboard bench: stimulus queues per-frame expectations, a monitor checks them.
module tb_fighter_controller;
  import fighter_pkg::*;

  localparam int F_MOVE = 8;
  localparam int F_ATK  = 4;
  localparam int F_DIR  = 2;
  localparam int F_KO   = 1;

  logic       logic_clk = 1'b0;
  logic       reset, in_left, in_right, attack, opp_dir_attack, own_hit;
  logic       in_left1, in_right1;
  logic [1:0] stunmode;
  logic [9:0] pos0, pos1;
  logic [3:0] st0, st1;
  logic [6:0] hp0, hp1;
  logic       mv0, at0, dr0, ko0, mv1, at1, dr1, ko1;

  typedef struct {
    int at;
    int unit_id;
    int st;
    int pos;
    int hp;
    int flg;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc    = 0;
  int    n_vec  = 0;
  int    n_fail = 0;

  always #5 logic_clk = ~logic_clk;

  fighter_controller dut0 (
    .logic_clk(logic_clk), .reset(reset), .in_left(in_left), .in_right(in_right),
    .attack(attack), .opp_pos_x(10'd200), .left_bound(10'd0), .right_bound(10'd639),
    .stunmode(stunmode), .opp_dir_attack(opp_dir_attack), .own_hit(own_hit),
    .pos_x(pos0), .state(st0), .move_flag(mv0), .attack_flag(at0),
    .is_directional_attack(dr0), .health(hp0), .ko(ko0)
  );

  fighter_controller #(.FACING(1), .START_X(400)) dut1 (
    .logic_clk(logic_clk), .reset(reset), .in_left(in_left1), .in_right(in_right1),
    .attack(attack), .opp_pos_x(10'd100), .left_bound(10'd0), .right_bound(10'd639),
    .stunmode(stunmode), .opp_dir_attack(opp_dir_attack), .own_hit(own_hit),
    .pos_x(pos1), .state(st1), .move_flag(mv1), .attack_flag(at1),
    .is_directional_attack(dr1), .health(hp1), .ko(ko1)
  );

  task automatic tick();
    @(negedge logic_clk);
  endtask

  // Expectation for the state seen right after the next rising edge.
  task automatic expect_next(input int u, input int st, input int pos, input int hp,
                             input int flg, input string nm);
    exp_t e;
    e.at = cyc + 1; e.unit_id = u; e.st = st; e.pos = pos; e.hp = hp; e.flg = flg;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every frame, compare all expectations due at this edge.
  initial begin : monitor
    exp_t  e;
    string nm;
    int    a_st, a_pos, a_hp, a_flg;
    bit    ok;
    forever begin
      @(posedge logic_clk);
      cyc++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.unit_id == 0) begin
          a_st = int'(st0); a_pos = int'(pos0); a_hp = int'(hp0);
          a_flg = int'({mv0, at0, dr0, ko0});
        end else begin
          a_st = int'(st1); a_pos = int'(pos1); a_hp = int'(hp1);
          a_flg = int'({mv1, at1, dr1, ko1});
        end
        ok = (e.at == cyc) && (a_st == e.st) && (e.pos < 0 || a_pos == e.pos) &&
             (e.hp < 0 || a_hp == e.hp) && (e.flg < 0 || a_flg == e.flg);
        n_vec++;
        if (!ok) begin
          n_fail++;
          $display("FAIL %s frame %0d: got st=%0d pos=%0d hp=%0d flags=%0d, want st=%0d pos=%0d hp=%0d flags=%0d",
                   nm, cyc, a_st, a_pos, a_hp, a_flg, e.st, e.pos, e.hp, e.flg);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b1; in_left = 1'b0; in_right = 1'b0; attack = 1'b0;
    opp_dir_attack = 1'b0; own_hit = 1'b0; stunmode = 2'b00;
    in_left1 = 1'b0; in_right1 = 1'b0;
    tick();
    expect_next(0, ST_IDLE, 10, 100, 0, "reset0");
    expect_next(1, ST_IDLE, 400, 100, 0, "reset1");
    tick();
    reset = 1'b0;

    // Left-facing unit: in_left is forward (-3), in_right is backward (+2).
    in_left1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      expect_next(1, ST_FORWARD, 400 - 3*i, 100, F_MOVE, "f1_fwd"); tick();
    end
    in_left1 = 1'b0; in_right1 = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      expect_next(1, ST_BACKWARD, 391 + 2*i, 100, F_MOVE, "f1_bwd"); tick();
    end
    in_right1 = 1'b0;
    expect_next(1, ST_IDLE, 395, 100, 0, "f1_idle"); tick();

    // Walk right until the next step would overlap the opponent at 200.
    in_right = 1'b1;
    for (int i = 1; i <= 42; i++) begin
      expect_next(0, ST_FORWARD, 10 + 3*i, 100, F_MOVE, "walk_fwd"); tick();
    end
    expect_next(0, ST_IDLE, 136, 100, 0, "walk_stop"); tick();
    expect_next(0, ST_IDLE, 136, 100, 0, "walk_hold"); tick();
    in_right = 1'b0; in_left = 1'b1;
    expect_next(0, ST_BACKWARD, 134, 100, F_MOVE, "walk_back"); tick();
    expect_next(0, ST_BACKWARD, 132, 100, F_MOVE, "walk_back"); tick();
    in_right = 1'b1;
    expect_next(0, ST_IDLE, 132, 100, 0, "both_held"); tick();
    in_left = 1'b0; in_right = 1'b0;

    // Intermediate attack, directional press buffered at recovery counter 12.
    attack = 1'b1;
    expect_next(0, ST_I_START, 132, 100, 0, "i_start"); tick();
    attack = 1'b0;
    repeat (4) begin expect_next(0, ST_I_START, 132, 100, 0, "i_start"); tick(); end
    repeat (2) begin expect_next(0, ST_I_ACTIVE, 132, 100, F_ATK, "i_active"); tick(); end
    for (int j = 0; j < 16; j++) begin
      attack = (j == 13); in_right = (j == 13);
      expect_next(0, ST_I_RECOV, 132, 100, 0, "i_recov"); tick();
    end
    attack = 1'b0; in_right = 1'b0;
    repeat (4) begin expect_next(0, ST_D_START, 132, 100, 0, "buf_d_start"); tick(); end
    repeat (3) begin expect_next(0, ST_D_ACTIVE, 132, 100, F_DIR, "d_active"); tick(); end
    for (int j = 0; j < 5; j++) begin
      stunmode = (j == 2) ? 2'b10 : 2'b00;
      expect_next(0, ST_D_RECOV, 132, 100, 0, "recov_block_ign"); tick();
    end
    stunmode = 2'b01;
    expect_next(0, ST_HITSTUN, 132, 90, 0, "recov_hit"); tick();
    stunmode = 2'b00;
    repeat (13) begin expect_next(0, ST_HITSTUN, 132, 90, 0, "hitstun"); tick(); end
    expect_next(0, ST_IDLE, 132, 90, 0, "hitstun_end"); tick();

    // own_hit shortens the active phase; press at recovery counter 10 is too early.
    attack = 1'b1;
    expect_next(0, ST_I_START, 132, 90, 0, "oh_start"); tick();
    attack = 1'b0;
    repeat (4) begin expect_next(0, ST_I_START, 132, 90, 0, "oh_start"); tick(); end
    expect_next(0, ST_I_ACTIVE, 132, 90, F_ATK, "oh_active"); tick();
    own_hit = 1'b1;
    expect_next(0, ST_I_RECOV, 132, 90, 0, "oh_recov"); tick();
    own_hit = 1'b0;
    for (int j = 1; j < 16; j++) begin
      attack = (j == 11);
      expect_next(0, ST_I_RECOV, 132, 90, 0, "oh_recov"); tick();
    end
    attack = 1'b0;
    expect_next(0, ST_IDLE, 132, 90, 0, "early_press_ign"); tick();

    // Blockstun ignores a hit arriving during it.
    stunmode = 2'b10;
    expect_next(0, ST_BLOCKSTUN, 132, 90, 0, "block"); tick();
    for (int j = 1; j < 12; j++) begin
      stunmode = (j == 5) ? 2'b01 : 2'b00;
      expect_next(0, ST_BLOCKSTUN, 132, 90, 0, "block"); tick();
    end
    stunmode = 2'b00;
    expect_next(0, ST_IDLE, 132, 90, 0, "block_end"); tick();

    // Directional hit (-15), then a re-hit during hitstun (-10) restarts the phase.
    opp_dir_attack = 1'b1; stunmode = 2'b01;
    expect_next(0, ST_HITSTUN, 132, 75, 0, "hit_dir"); tick();
    opp_dir_attack = 1'b0;
    for (int j = 1; j < 20; j++) begin
      stunmode = (j == 6) ? 2'b01 : 2'b00;
      expect_next(0, ST_HITSTUN, 132, (j < 6) ? 75 : 65, 0, "rehit"); tick();
    end
    stunmode = 2'b00;
    expect_next(0, ST_IDLE, 132, 65, 0, "rehit_end"); tick();

    // Reset asserted in the middle of a directional active phase.
    attack = 1'b1; in_left = 1'b1;
    expect_next(0, ST_D_START, 132, 65, 0, "d_start"); tick();
    attack = 1'b0; in_left = 1'b0;
    repeat (3) begin expect_next(0, ST_D_START, 132, 65, 0, "d_start"); tick(); end
    repeat (2) begin expect_next(0, ST_D_ACTIVE, 132, 65, F_DIR, "d_active2"); tick(); end
    reset = 1'b1;
    expect_next(0, ST_IDLE, 10, 100, 0, "reset_mid"); tick();
    reset = 1'b0;
    expect_next(0, ST_IDLE, 10, 100, 0, "post_reset"); tick();

    // Ten hits drain health to zero, then KO absorbs all inputs.
    stunmode = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      expect_next(0, ST_HITSTUN, 10, 100 - 10*k, 0, "drain"); tick();
    end
    stunmode = 2'b00; in_right = 1'b1; attack = 1'b1;
    repeat (3) begin expect_next(0, ST_KO, 10, 0, F_KO, "ko"); tick(); end
    in_right = 1'b0; attack = 1'b0;
    reset = 1'b1;
    expect_next(0, ST_IDLE, 10, 100, 0, "reset_ko"); tick();
    reset = 1'b0;
    repeat (3) tick();

    if (exp_q.size() != 0) begin
      $display("FAIL leftover: got %0d unchecked expectations, want 0", exp_q.size());
      n_fail += exp_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
